// File: rtl/frame_streamer.sv
// Frame RAM to pixel-stream transmitter: replays one Width x Height frame in raster
// order as a PixelOut/FrameOut/LineOut stream with front porch, line blanking and back porch.
module frame_streamer #(
    parameter int ADDR_W = 16,
    parameter int FRONT  = 2,
    parameter int HBLANK = 3,
    parameter int BACK   = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [7:0]        Width,
    input  logic [7:0]        Height,
    output logic              RdEn,
    output logic [ADDR_W-1:0] RdAddr,
    input  logic [7:0]        RdData,
    output logic [7:0]        PixelOut,
    output logic              FrameOut,
    output logic              LineOut,
    output logic              Busy,
    output logic              Done
);

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FRONT,
        S_LINE,
        S_HBL,
        S_BACK,
        S_ZERO
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       line_cnt;
    logic [7:0]       width_q;
    logic [7:0]       height_q;
    logic             accept;
    logic             in_frame;
    logic             in_line;
    logic             frame_p1;
    logic             line_p1;
    logic             last_col;
    logic             addr_step;

    // Busy stays high until the delayed flags have drained, so Done's cycle is idle.
    assign Busy      = (state != S_IDLE) || frame_p1 || FrameOut;
    assign accept    = Start && !Busy;
    assign in_frame  = (state == S_FRONT) || (state == S_LINE) ||
                       (state == S_HBL)   || (state == S_BACK);
    assign in_line   = (state == S_LINE);
    assign last_col  = (cnt == CNT_W'(width_q) - CNT_W'(1));
    assign addr_step = ((state == S_LINE) || (state == S_HBL)) && (state_next == S_LINE);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if ((Width == 8'd0) || (Height == 8'd0)) state_next = S_ZERO;
                    else                                     state_next = S_FRONT;
                end
            end
            S_FRONT: if (cnt == CNT_W'(FRONT - 1))  state_next = S_LINE;
            S_LINE: begin
                if (last_col) begin
                    if (line_cnt == height_q - 8'd1) state_next = S_BACK;
                    else                             state_next = S_HBL;
                end
            end
            S_HBL:   if (cnt == CNT_W'(HBLANK - 1)) state_next = S_LINE;
            S_BACK:  if (cnt == CNT_W'(BACK - 1))   state_next = S_IDLE;
            S_ZERO:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (accept) begin
            width_q  <= Width;
            height_q <= Height;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            line_cnt <= '0;
            RdEn     <= 1'b0;
            RdAddr   <= '0;
            frame_p1 <= 1'b0;
            line_p1  <= 1'b0;
            FrameOut <= 1'b0;
            LineOut  <= 1'b0;
            PixelOut <= '0;
            Done     <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? '0 : cnt + CNT_W'(1);
            if (accept)                                      line_cnt <= '0;
            else if (state == S_LINE && state_next == S_HBL) line_cnt <= line_cnt + 8'd1;

            RdEn <= (state_next == S_LINE);
            if (accept)         RdAddr <= '0;
            else if (addr_step) RdAddr <= RdAddr + ADDR_W'(1);

            // p1: flags wait out the RAM read cycle
            frame_p1 <= in_frame;
            line_p1  <= in_line;

            // output register: LineOut lines up with the returned RAM data
            FrameOut <= frame_p1;
            LineOut  <= line_p1;
            PixelOut <= line_p1 ? RdData : 8'd0;
            Done     <= (state == S_ZERO) || (FrameOut && !frame_p1);
        end
    end

endmodule
